pkt_transmit: RTL and testbench



---
 rtl/pkt_transmit.sv | 190 +++++++++++++++++++
 tb/tb_pkt_transmit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_transmit.sv
// GMII transmit framer: reads head/tail-flagged bytes from a show-ahead FIFO, adds preamble/SFD,
// enforces the inter-frame gap and aborts frames on underflow. Define TX_FCS_APPEND_EN to append CRC-32.
module pkt_transmit #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [8:0] iv_data,
  input  logic       i_data_empty,
  output logic       o_data_rd,
  output logic [7:0] ov_gmii_txd,
  output logic       o_gmii_tx_en,
  output logic       o_gmii_tx_er,
  output logic       o_pkt_sent_pulse,
  output logic       o_fifo_underflow_pulse
);

  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int IW = $clog2(IFG_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN);
  localparam logic [IW-1:0] IFG_MAX  = IW'(IFG_CYCLES);
  localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_FLUSH, S_IFG, S_FCS
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [IW-1:0] ifg_cnt_q, ifg_cnt_d;
  logic          resync_q, resync_d;
  logic [7:0]    txd_q, txd_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_er_q, tx_er_d;
  logic          sent_q, sent_d;
  logic          uf_q, uf_d;
  logic          rd;
  logic          ifg_met;

`ifdef TX_FCS_APPEND_EN
  logic [31:0] crc_q, crc_d;
  logic [1:0]  fcs_cnt_q, fcs_cnt_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction
`endif

  // The current cycle counts toward the gap, so the last low cycle of the gap can already launch a frame.
  assign ifg_met = !tx_en_q && (ifg_cnt_q >= IFG_LAST);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    resync_d  = resync_q;
    txd_d     = 8'h00;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    sent_d    = 1'b0;
    uf_d      = 1'b0;
    rd        = 1'b0;
    ifg_cnt_d = ifg_cnt_q;
    if (tx_en_q) ifg_cnt_d = '0;
    else if (ifg_cnt_q < IFG_MAX) ifg_cnt_d = ifg_cnt_q + 1'b1;
`ifdef TX_FCS_APPEND_EN
    crc_d     = crc_q;
    fcs_cnt_d = fcs_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_IFG: begin
        if (state_q == S_IFG && ifg_met) state_d = S_IDLE;
        if (!i_data_empty) begin
          if (!iv_data[8]) begin
            rd = 1'b1;
            // A data byte right after reset means a frame was cut mid-way: discard through its tail.
            if (resync_q) begin
              resync_d = 1'b0;
              state_d  = S_FLUSH;
            end
          end else if (ifg_met) begin
            resync_d  = 1'b0;
            state_d   = S_PRE;
            pre_cnt_d = PW'(1);
            txd_d     = 8'h55;
            tx_en_d   = 1'b1;
          end
        end
      end
      S_PRE: begin
        tx_en_d = 1'b1;
        if (pre_cnt_q >= PRE_LAST) begin
          txd_d   = 8'hD5;
          state_d = S_SFD;
        end else begin
          txd_d     = 8'h55;
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      S_SFD, S_DATA: begin
        tx_en_d = 1'b1;
        if (i_data_empty) begin
          tx_er_d = 1'b1;
          uf_d    = 1'b1;
          state_d = S_FLUSH;
        end else begin
          rd      = 1'b1;
          txd_d   = iv_data[7:0];
          state_d = S_DATA;
`ifdef TX_FCS_APPEND_EN
          crc_d = crc32_byte((state_q == S_SFD) ? 32'hFFFFFFFF : crc_q, iv_data[7:0]);
`endif
          if (state_q == S_DATA && iv_data[8]) begin
`ifdef TX_FCS_APPEND_EN
            state_d   = S_FCS;
            fcs_cnt_d = 2'd0;
`else
            sent_d  = 1'b1;
            state_d = S_IFG;
`endif
          end
        end
      end
      S_FLUSH: begin
        if (!i_data_empty) begin
          rd = 1'b1;
          if (iv_data[8]) state_d = S_IFG;
        end
      end
      S_FCS: begin
`ifdef TX_FCS_APPEND_EN
        tx_en_d = 1'b1;
        txd_d   = ~crc_q[{fcs_cnt_q, 3'b000} +: 8];
        if (fcs_cnt_q == 2'd3) begin
          sent_d  = 1'b1;
          state_d = S_IFG;
        end else begin
          fcs_cnt_d = fcs_cnt_q + 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      ifg_cnt_q <= IFG_MAX;
      resync_q  <= 1'b1;
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      sent_q    <= 1'b0;
      uf_q      <= 1'b0;
`ifdef TX_FCS_APPEND_EN
      crc_q     <= 32'hFFFFFFFF;
      fcs_cnt_q <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      ifg_cnt_q <= ifg_cnt_d;
      resync_q  <= resync_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      sent_q    <= sent_d;
      uf_q      <= uf_d;
`ifdef TX_FCS_APPEND_EN
      crc_q     <= crc_d;
      fcs_cnt_q <= fcs_cnt_d;
`endif
    end
  end

  assign o_data_rd              = rd & reset_n;
  assign ov_gmii_txd            = txd_q;
  assign o_gmii_tx_en           = tx_en_q;
  assign o_gmii_tx_er           = tx_er_q;
  assign o_pkt_sent_pulse       = sent_q;
  assign o_fifo_underflow_pulse = uf_q;

endmodule

// File: tb/tb_pkt_transmit.sv
// Scoreboard bench for pkt_transmit: a FIFO model feeds frames, expected GMII cycles are queued
// by the stimulus and a negedge monitor compares every tx_en cycle and inter-frame gap.
module tb_pkt_transmit;
  localparam int IFG = 12;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] iv_data;
  logic       i_data_empty;
  logic       o_data_rd;
  logic [7:0] ov_gmii_txd;
  logic       o_gmii_tx_en, o_gmii_tx_er, o_pkt_sent_pulse, o_fifo_underflow_pulse;

  pkt_transmit #(.PREAMBLE_LEN(7), .IFG_CYCLES(IFG)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .iv_data(iv_data), .i_data_empty(i_data_empty),
    .o_data_rd(o_data_rd), .ov_gmii_txd(ov_gmii_txd), .o_gmii_tx_en(o_gmii_tx_en),
    .o_gmii_tx_er(o_gmii_tx_er), .o_pkt_sent_pulse(o_pkt_sent_pulse),
    .o_fifo_underflow_pulse(o_fifo_underflow_pulse)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] d;
    logic       er;
    logic       sent;
    logic       uf;
  } exp_t;

  exp_t       exp_q[$];
  int         gap_q[$];
  logic [8:0] fifo_q[$];
  logic [8:0] fr[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         pops = 0;
  int         low_run = 1000;
  logic       rd_s = 1'b0;
  logic       prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_true(input string name, input logic cond);
    check(name, 32'(cond), 32'd1);
  endtask

  function automatic void refresh();
    i_data_empty = (fifo_q.size() == 0);
    iv_data      = (fifo_q.size() != 0) ? fifo_q[0] : 9'h000;
  endfunction

  // FIFO model: pop decision sampled mid-cycle, applied just after the edge.
  always @(negedge clk_sys) rd_s = o_data_rd;
  always @(posedge clk_sys) begin
    #1;
    if (rd_s) begin
      check_true("pop_on_empty", fifo_q.size() != 0);
      if (fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pops++;
        refresh();
      end
    end
  end

  always @(negedge clk_sys) begin
    int   g;
    exp_t e;
    if (o_gmii_tx_en) begin
      if (!prev_en) begin
        check_true("frame_start_expected", gap_q.size() != 0);
        if (gap_q.size() != 0) begin
          g = gap_q.pop_front();
          if (g >= 0) check("ifg_exact", 32'(low_run), 32'(g));
          else if (g == -2) check_true("ifg_min", low_run >= IFG);
        end
      end
      check_true("tx_cycle_expected", exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("txd", 32'(ov_gmii_txd), 32'(e.d));
        check("tx_er", 32'(o_gmii_tx_er), 32'(e.er));
        check("sent_pulse", 32'(o_pkt_sent_pulse), 32'(e.sent));
        check("underflow_pulse", 32'(o_fifo_underflow_pulse), 32'(e.uf));
      end
      low_run = 0;
    end else begin
      check("idle_quiet", 32'({ov_gmii_txd, o_gmii_tx_er, o_pkt_sent_pulse, o_fifo_underflow_pulse}), 32'd0);
      if (low_run < 100000) low_run++;
    end
    prev_en = o_gmii_tx_en;
  end

  task automatic make_frame(input int first, input int len, input int step);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back({(i == 0 || i == len - 1), 8'(first + i * step)});
  endtask

  task automatic load(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) fifo_q.push_back(fr[i]);
    refresh();
  endtask

  task automatic exp_push(input logic [7:0] d, input logic er, input logic sent, input logic uf);
    exp_t e;
    e.d = d; e.er = er; e.sent = sent; e.uf = uf;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] crc_model(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fr[i][7:0]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // mode 0: complete frame; 1: first nbytes then abort cycle; 2: first nbytes then cut by reset
  task automatic expect_frame(input int nbytes, input int mode, input int gap);
    logic [31:0] crc;
    gap_q.push_back(gap);
    for (int i = 0; i < 7; i++) exp_push(8'h55, 1'b0, 1'b0, 1'b0);
    exp_push(8'hD5, 1'b0, 1'b0, 1'b0);
    if (mode == 0) begin
`ifdef TX_FCS_APPEND_EN
      for (int i = 0; i < nbytes; i++) exp_push(fr[i][7:0], 1'b0, 1'b0, 1'b0);
      crc = crc_model(nbytes);
      for (int k = 0; k < 4; k++) exp_push(crc[8*k +: 8], 1'b0, (k == 3), 1'b0);
`else
      crc = 32'h0;
      for (int i = 0; i < nbytes; i++) exp_push(fr[i][7:0], 1'b0, (i == nbytes - 1), 1'b0);
`endif
    end else begin
      for (int i = 0; i < nbytes; i++) exp_push(fr[i][7:0], 1'b0, 1'b0, 1'b0);
      if (mode == 1) exp_push(8'h00, 1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check_true({name, "_completed"}, n < budget);
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_txd"}, 32'(ov_gmii_txd), 32'd0);
    check({name, "_tx_en"}, 32'(o_gmii_tx_en), 32'd0);
    check({name, "_tx_er"}, 32'(o_gmii_tx_er), 32'd0);
    check({name, "_sent"}, 32'(o_pkt_sent_pulse), 32'd0);
    check({name, "_uf"}, 32'(o_fifo_underflow_pulse), 32'd0);
    check({name, "_rd"}, 32'(o_data_rd), 32'd0);
  endtask

  initial begin
    int n;
    refresh();
    // Reset state with a head already waiting in the FIFO
    make_frame(8'h00, 64, 1);
    load(0, 63);
    idle(3);
    check_outputs_zero("reset");
    expect_frame(64, 0, -1);
    pops = 0;
    reset_n = 1'b1;
    wait_drain("t1", 300);
    check("t1_pops", 32'(pops), 32'd64);

    // Two back-to-back frames
    idle(20);
    pops = 0;
    make_frame(8'h80, 64, 1);
    load(0, 63);
    expect_frame(64, 0, -1);
    make_frame(3, 64, 3);
    load(0, 63);
    expect_frame(64, 0, IFG);
    wait_drain("t2", 600);
    check("t2_pops", 32'(pops), 32'd128);

    // Underflow after byte 20, flush of the rest, then a normal frame
    idle(20);
    pops = 0;
    make_frame(8'h10, 64, 1);
    load(0, 20);
    expect_frame(21, 1, -1);
    wait_drain("t3_abort", 200);
    load(21, 63);
    make_frame(8'h20, 64, 2);
    load(0, 63);
    expect_frame(64, 0, -2);
    wait_drain("t3_next", 600);
    check("t3_pops", 32'(pops), 32'd128);

    // Stray bytes ahead of a frame
    idle(20);
    pops = 0;
    fifo_q.push_back(9'h011);
    fifo_q.push_back(9'h022);
    fifo_q.push_back(9'h033);
    make_frame(8'hA0, 8, 1);
    load(0, 7);
    expect_frame(8, 0, -1);
    wait_drain("t4", 200);
    check("t4_pops", 32'(pops), 32'd11);

`ifdef TX_FCS_APPEND_EN
    // 60 zero bytes with FCS appended
    idle(20);
    pops = 0;
    make_frame(0, 60, 0);
    load(0, 59);
    expect_frame(60, 0, -1);
    wait_drain("t5", 300);
    check("t5_pops", 32'(pops), 32'd60);
`endif

    // Reset mid-frame at data byte 30
    idle(20);
    pops = 0;
    make_frame(8'h30, 64, 1);
    load(0, 63);
    expect_frame(30, 2, -1);
    n = 0;
    while (!o_gmii_tx_en && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check_true("t6_frame_started", n < 200);
    repeat (38) @(posedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_async_reset");
    idle(3);
    reset_n = 1'b1;
    make_frame(8'h90, 16, 1);
    load(0, 15);
    expect_frame(16, 0, -1);
    wait_drain("t6", 400);
    check("t6_pops", 32'(pops), 32'd80);

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
